// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register scoreboard busy bit
// and a sequential self-clear that runs after reset or on request.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clk_en          gates writes and allocs (clear sequencer runs regardless)
//   raddr/rdata     NRD read ports, combinational data with write bypass
//   rbusy           scoreboard busy bit of each read address (no bypass)
//   we/waddr/wdata  NWR write ports, highest index wins on address collision
//   alloc/alloc_addr mark a register busy (pending write)
//   clear_req       restart the clear of array and scoreboard
//   ready           high once the clear has finished and ports are live
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                clear_req,
    output logic                ready
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [XLEN-1:0]       regs_q [NREGS];
    logic [XLEN-1:0]       regs_d [NREGS];

    logic [NWR-1:0]        commit_c;
    logic                  alloc_ok_c;
    logic                  live_c;

    assign live_c = (state_q == ST_READY);
    assign ready  = live_c;

    // Per-port write commit qualification and alloc qualification.
    always_comb begin
        commit_c = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            commit_c[j] = we[j] && clk_en && live_c && !clear_req &&
                          !((ZERO_REG != 0) && (waddr[j*AW +: AW] == '0));
        end
        alloc_ok_c = alloc && clk_en && live_c && !clear_req &&
                     !((ZERO_REG != 0) && (alloc_addr == '0));
    end

    // Next-state: clear sequencer, writes, scoreboard updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        regs_d  = regs_q;
        if (clear_req) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            busy_d  = '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    regs_d[cnt_q] = '0;
                    cnt_d         = cnt_q + AW'(1);
                    if (cnt_q == LAST_REG) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    // Ascending order lets the highest committing port win.
                    for (int unsigned j = 0; j < NWR; j++) begin
                        if (commit_c[j]) begin
                            regs_d[waddr[j*AW +: AW]] = wdata[j*XLEN +: XLEN];
                            busy_d[waddr[j*AW +: AW]] = 1'b0;
                        end
                    end
                    // Alloc applied last so it wins over a same-cycle write.
                    if (alloc_ok_c) begin
                        busy_d[alloc_addr] = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Read ports: bypass from committing writes, zero register, forced 0 while clearing.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] rd;
            ra = raddr[i*AW +: AW];
            rd = regs_q[ra];
            for (int unsigned j = 0; j < NWR; j++) begin
                if (commit_c[j] && (waddr[j*AW +: AW] == ra)) begin
                    rd = wdata[j*XLEN +: XLEN];
                end
            end
            if (!live_c || ((ZERO_REG != 0) && (ra == '0))) begin
                rdata[i*XLEN +: XLEN] = '0;
                rbusy[i]              = 1'b0;
            end else begin
                rdata[i*XLEN +: XLEN] = rd;
                rbusy[i]              = busy_q[ra];
            end
        end
    end

    // Control state and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Array storage; contents are defined by the clear sequence, not by reset.
    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, 32, data width in bits (≥1).
REQ-002 Parameter NREGS, 32, register count (power of two, ≥2); AW = log2(NREGS).
REQ-003 Parameter NRD, 2, read port count (≥1).
REQ-004 Parameter NWR, 1, write port count (≥1).
REQ-005 Parameter ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes/allocs.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 clk_en  in  1  gates writes and allocs (not the clear sequencer).
REQ-009 raddr  in  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-010 rdata  out  NRD*XLEN  read data, combinational; port i at [i*XLEN +: XLEN].
REQ-011 rbusy  out  NRD  scoreboard busy bit of each read address.
REQ-012 we  in  NWR  write enables.
REQ-013 waddr  in  NWR*AW  write addresses.
REQ-014 wdata  in  NWR*XLEN  write data.
REQ-015 alloc  in  1  mark alloc_addr busy (pending write).
REQ-016 alloc_addr  in  AW  register to allocate.
REQ-017 clear_req  in  1  request full re-clear of array and scoreboard.
REQ-018 ready  out  1  high when array is cleared and ports are live.

Function
REQ-019 FSM states CLEAR and READY; reset enters CLEAR with counter 0.
REQ-020 In CLEAR, each rising edge writes zero to register[counter] and increments counter, independent of clk_en.
REQ-021 Edge that writes register NREGS-1 moves FSM to READY; ready=1 from that edge, i.e. NREGS edges after rst_n release.
REQ-022 clear_req=1 at an edge (any state) zeroes counter, clears all busy bits, enters CLEAR; ready=0 next cycle; in-flight CLEAR restarts.
REQ-023 In CLEAR: writes and allocs ignored, rdata=0, rbusy=0.
REQ-024 Commit condition per port j: we[j] && clk_en && ready && !(ZERO_REG && waddr_j==0) && !clear_req.
REQ-025 Committed write updates register[waddr_j] <= wdata_j at edge.
REQ-026 Multiple ports committing to one address same cycle: highest-index port wins.
REQ-027 Read port i: ZERO_REG && raddr_i==0 -> 0; else if any port commits to raddr_i this cycle -> that port's wdata (highest index wins); else register[raddr_i].
REQ-028 Committed write to address r clears busy[r] at edge.
REQ-029 alloc && clk_en && ready && !clear_req && !(ZERO_REG && alloc_addr==0) sets busy[alloc_addr] at edge.
REQ-030 Same-cycle alloc and committed write to same address: busy ends set (alloc wins).
REQ-031 rbusy[i] = busy[raddr_i] (current state, no bypass of same-cycle write/alloc); 0 for reg 0 when ZERO_REG.
REQ-032 clk_en=0: no write or busy change; reads and bypass-free rdata remain valid.

Reset
REQ-033 rst_n low asynchronously: ready=0, FSM=CLEAR, counter=0, all busy=0; array contents undefined until clear completes.
REQ-034 Assertion mid-CLEAR or mid-READY aborts immediately; full clear rerun after release.

Verification
REQ-035 Release reset, NREGS=32, idle -> ready=0 for 32 edges, 1 after 32nd; all reads return 0.
REQ-036 READY, we[0]=1 waddr=5 wdata=0xDEADBEEF, raddr0=5 same cycle -> rdata0=0xDEADBEEF combinationally; next cycle with we=0 still 0xDEADBEEF.
REQ-037 Write 0x1234 to reg 0 (ZERO_REG=1), alloc reg 0 -> raddr=0 gives rdata=0, rbusy=0.
REQ-038 alloc reg 7 -> rbusy=1 next cycle; write reg 7 with alloc reg 7 same cycle -> rbusy stays 1; write alone -> rbusy=0.
REQ-039 NWR=2, both ports write reg 3 (0xA, 0xB) -> bypass and stored value 0xB.
REQ-040 Regs loaded, clear_req pulse mid-operation, then rst_n pulse during the re-clear -> ready low, busy cleared, re-clear completes NREGS edges after release, all regs 0.
